frame_sequencer: RTL and testbench
==================================

// Module: frame_sequencer
// PURPOSE
//   Framing controller in front of line_buffer. Latches per-frame geometry on a start pulse, then passes an
//   unframed pixel stream through. Generates o_eor/o_eof, and appends PAD_ROWS bottom-pad rows of PAD_VAL so the
//   last image rows reach the kernel window. Signals completion once the final eof beat is accepted downstream.
// PARAMETERS
//   DATA_W     8    pixel width
//   MAX_IMG_W  640  max columns (line_buffer depth)
//   MAX_IMG_H  480  max rows
//   KERNEL_H   7    kernel height; bounds i_pad_rows
//   PAD_VAL    0    value of generated pad pixels
// PORTS
//   i_clk        in   1                        clock
//   i_rst_n      in   1                        reset, asynchronous, active-low
//   i_start      in   1                        start pulse; sampled only in IDLE
//   i_img_w      in   $clog2(MAX_IMG_W+1)      columns per row, latched on start
//   i_img_h      in   $clog2(MAX_IMG_H+1)      image rows, latched on start
//   i_pad_rows   in   $clog2(KERNEL_H)         pad rows after image, latched on start
//   i_vld        in   1                        upstream pixel valid
//   i_data       in   DATA_W                   upstream pixel
//   o_rdy        out  1                        upstream ready
//   i_rdy        in   1                        downstream (line_buffer) ready
//   o_vld        out  1                        downstream valid
//   o_eor        out  1                        last pixel of row
//   o_eof        out  1                        last pixel of frame (incl. pad)
//   o_data       out  DATA_W                   pixel
//   o_busy       out  1                        high in any state except IDLE
//   o_done       out  1                        1-cycle pulse at frame completion
//   o_err        out  1                        1-cycle pulse on rejected start
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; o_vld/o_eor/o_eof/o_done/o_err=0, o_data=0, o_busy=0,
//     counters=0. A mid-frame reset abandons the frame; no eof is emitted.
//   Output stage: registered. A beat transfers when o_vld && i_rdy. While o_vld && !i_rdy,
//     o_vld/o_data/o_eor/o_eof hold stable. Stage load enable ld = !o_vld || i_rdy.
//   o_rdy = (state==RUN) && ld, combinational. Latency from input accept to o_vld is 1 cycle.
//   Counters: col 0..w-1 and row 0..h+pad-1 advance on every beat loaded into the stage.
//     At col==w-1 the loaded beat has eor=1, col wraps to 0 and row increments.
//   States:
//     IDLE: o_rdy=0. On i_start, check the geometry:
//       - if w==0, h==0, w>MAX_IMG_W, h>MAX_IMG_H or pad>KERNEL_H-1: o_err=1 for 1 cycle, stay IDLE;
//       - otherwise latch w/h/pad, clear counters, go to RUN.
//     RUN: accept pixels. On the load of the beat with row==h-1 && col==w-1:
//       - pad==0: eof=1, go to DRAIN;
//       - else go to PAD.
//     PAD: o_rdy=0. Load PAD_VAL beats whenever ld. The last pad pixel (row==h+pad-1, col==w-1) has eor=eof=1,
//       then go to DRAIN.
//     DRAIN: wait until the eof beat transfers; that same cycle o_vld=0 next, o_done=1 next cycle, go to IDLE.
//   Edge cases:
//     - w==1: every beat has eor=1.
//     - w==1 && h==1 && pad==0: the single beat has eor=eof=1.
//   i_start is ignored while busy, including i_start in the same cycle as the o_done transition. Upstream data
//     presented outside RUN is not accepted. Inputs i_img_* may change freely after start.
// TESTING
//   1. w=4,h=2,pad=0, i_rdy=1, 8 pixels 1..8 -> o_data 1..8 one cycle after accept; eor on 4,8; eof on 8;
//      o_done pulses 1 cycle after pixel 8 transfers.
//   2. w=3,h=2,pad=2, PAD_VAL=0 -> 6 image beats then 6 zero beats; eor on beats 3,6,9,12; eof only on beat 12;
//      o_rdy=0 during pad.
//   3. Backpressure: w=4,h=1, i_rdy low 3 cycles mid-row -> o_data/o_eor held stable, o_rdy=0,
//      no pixel lost or duplicated.
//   4. i_start with w=0, then w=641 (MAX_IMG_W=640), then pad=7 (KERNEL_H=7) -> o_err pulse each time;
//      o_busy stays 0.
//   5. i_rst_n low at row 1 col 2 of w=4,h=3 -> all outputs 0 asynchronously; next start with w=2,h=1
//      gives eor/eof on beat 2.
//   6. i_start pulsed during RUN -> ignored; frame completes with original geometry.

Source files
------------

// File: rtl/frame_sequencer.sv
// Framing controller ahead of line_buffer: latches frame geometry on start, tags row/frame ends,
// appends bottom pad rows and pulses done once the final eof beat leaves the output stage.
module frame_sequencer #(
    parameter int DATA_W    = 8,
    parameter int MAX_IMG_W = 640,
    parameter int MAX_IMG_H = 480,
    parameter int KERNEL_H  = 7,
    parameter int PAD_VAL   = 0,
    localparam int W_W = $clog2(MAX_IMG_W + 1),
    localparam int H_W = $clog2(MAX_IMG_H + 1),
    localparam int P_W = $clog2(KERNEL_H)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [W_W-1:0]    i_img_w,
    input  logic [H_W-1:0]    i_img_h,
    input  logic [P_W-1:0]    i_pad_rows,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_rdy,
    input  logic              i_rdy,
    output logic              o_vld,
    output logic              o_eor,
    output logic              o_eof,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // state | meaning
    // IDLE  | waiting for start; geometry checked on start
    // RUN   | passing upstream pixels into the output stage
    // PAD   | generating PAD_VAL rows after the last image row
    // DRAIN | waiting for the eof beat to be taken downstream

    // Row index spans image plus pad rows, so it needs headroom beyond MAX_IMG_H.
    localparam int R_W = $clog2(MAX_IMG_H + KERNEL_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAD,
        S_DRAIN
    } state_t;

    state_t         state;
    logic [W_W-1:0] col;
    logic [W_W-1:0] w_last;
    logic [R_W-1:0] row;
    logic [R_W-1:0] row_img_last;
    logic [R_W-1:0] row_pad_last;
    logic           pad_none;

    logic ld;
    logic accept;
    logic col_last;
    logic img_last;
    logic pad_last;
    logic geom_bad;

    assign ld       = !o_vld || i_rdy;
    assign o_rdy    = (state == S_RUN) && ld;
    assign accept   = o_rdy && i_vld;
    assign col_last = (col == w_last);
    assign img_last = col_last && (row == row_img_last);
    assign pad_last = col_last && (row == row_pad_last);

    assign geom_bad = (i_img_w == '0) || (i_img_h == '0)
                   || (i_img_w > W_W'(MAX_IMG_W))
                   || (i_img_h > H_W'(MAX_IMG_H))
                   || (i_pad_rows > P_W'(KERNEL_H - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            col          <= '0;
            row          <= '0;
            w_last       <= '0;
            row_img_last <= '0;
            row_pad_last <= '0;
            pad_none     <= 1'b0;
            o_vld        <= 1'b0;
            o_eor        <= 1'b0;
            o_eof        <= 1'b0;
            o_data       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            // A transferred beat empties the stage unless a new one loads below.
            if (o_vld && i_rdy) begin
                o_vld <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (geom_bad) begin
                            o_err <= 1'b1;
                        end else begin
                            w_last       <= i_img_w - W_W'(1);
                            row_img_last <= R_W'(i_img_h) - R_W'(1);
                            row_pad_last <= R_W'(i_img_h) + R_W'(i_pad_rows) - R_W'(1);
                            pad_none     <= (i_pad_rows == '0);
                            col          <= '0;
                            row          <= '0;
                            o_busy       <= 1'b1;
                            state        <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (accept) begin
                        o_vld  <= 1'b1;
                        o_data <= i_data;
                        o_eor  <= col_last;
                        o_eof  <= img_last && pad_none;
                        if (col_last) begin
                            col <= '0;
                            row <= row + R_W'(1);
                        end else begin
                            col <= col + W_W'(1);
                        end
                        if (img_last) begin
                            state <= pad_none ? S_DRAIN : S_PAD;
                        end
                    end
                end

                S_PAD: begin
                    if (ld) begin
                        o_vld  <= 1'b1;
                        o_data <= DATA_W'(PAD_VAL);
                        o_eor  <= col_last;
                        o_eof  <= pad_last;
                        if (col_last) begin
                            col <= '0;
                            row <= row + R_W'(1);
                        end else begin
                            col <= col + W_W'(1);
                        end
                        if (pad_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    // Only the eof beat can occupy the stage here.
                    if (o_vld && i_rdy) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomised bench for frame_sequencer: a beat-index model of each frame predicts every
// transferred beat, handshake and status pulse; directed frames pin the model with literals.
module tb_frame_sequencer;

    localparam int DATA_W    = 8;
    localparam int MAX_IMG_W = 640;
    localparam int MAX_IMG_H = 480;
    localparam int KERNEL_H  = 7;
    localparam int PAD_VAL   = 0;
    localparam int W_W = $clog2(MAX_IMG_W + 1);
    localparam int H_W = $clog2(MAX_IMG_H + 1);
    localparam int P_W = $clog2(KERNEL_H);

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [W_W-1:0]    i_img_w = '0;
    logic [H_W-1:0]    i_img_h = '0;
    logic [P_W-1:0]    i_pad_rows = '0;
    logic              i_vld = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              o_rdy;
    logic              i_rdy = 1'b0;
    logic              o_vld;
    logic              o_eor;
    logic              o_eof;
    logic [DATA_W-1:0] o_data;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    frame_sequencer #(
        .DATA_W(DATA_W), .MAX_IMG_W(MAX_IMG_W), .MAX_IMG_H(MAX_IMG_H),
        .KERNEL_H(KERNEL_H), .PAD_VAL(PAD_VAL)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_img_w(i_img_w), .i_img_h(i_img_h), .i_pad_rows(i_pad_rows),
        .i_vld(i_vld), .i_data(i_data), .o_rdy(o_rdy), .i_rdy(i_rdy),
        .o_vld(o_vld), .o_eor(o_eor), .o_eof(o_eof), .o_data(o_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: beat k of a w x (h+pad) frame carries the k-th accepted pixel (or PAD_VAL),
    // eor when k%w==w-1, eof when k is the final beat.
    bit   m_busy = 1'b0;
    int   m_w, m_img, m_total;
    int   out_idx, acc_cnt;
    int   acc_q[$];
    bit   exp_done, exp_err, exp_vld, prev_hold;
    int   prev_d, prev_eor, prev_eof;
    int   cyc = 0, eof_cyc = 0, done_cyc = 0;
    bit   done_seen = 1'b0;
    int   err_seen = 0;
    int   lg_d[$], lg_eor[$], lg_eof[$];
    bit   busy_now, nx_done, nx_err, nx_vld, exp_rdy, bad;
    int   exp_d;

    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst_n) begin
            chk("rst_vld", int'(o_vld), 0);
            chk("rst_busy", int'(o_busy), 0);
            chk("rst_rdy", int'(o_rdy), 0);
            m_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_vld = 1'b0; prev_hold = 1'b0;
        end else begin
            busy_now = m_busy;
            chk("busy", int'(o_busy), int'(m_busy));
            chk("done", int'(o_done), int'(exp_done));
            chk("err", int'(o_err), int'(exp_err));
            if (o_done) begin done_seen = 1'b1; done_cyc = cyc; end
            if (o_err) err_seen++;
            exp_rdy = m_busy && (acc_cnt < m_img) && (!o_vld || i_rdy);
            chk("rdy", int'(o_rdy), int'(exp_rdy));
            if (!m_busy) chk("idle_vld", int'(o_vld), 0);
            if (exp_vld) chk("latency_vld", int'(o_vld), 1);
            if (prev_hold) begin
                chk("hold_vld", int'(o_vld), 1);
                chk("hold_data", int'(o_data), prev_d);
                chk("hold_eor", int'(o_eor), prev_eor);
                chk("hold_eof", int'(o_eof), prev_eof);
            end
            nx_done = 1'b0; nx_err = 1'b0; nx_vld = 1'b0;
            if (o_vld && i_rdy) begin
                chk("beat_in_frame", int'(m_busy && (out_idx < m_total)), 1);
                if (m_busy && out_idx < m_total) begin
                    if (out_idx >= m_img) exp_d = PAD_VAL;
                    else if (out_idx < acc_cnt) exp_d = acc_q[out_idx];
                    else exp_d = -1;
                    chk("data", int'(o_data), exp_d);
                    chk("eor", int'(o_eor), int'((out_idx % m_w) == m_w - 1));
                    chk("eof", int'(o_eof), int'(out_idx == m_total - 1));
                    lg_d.push_back(int'(o_data));
                    lg_eor.push_back(int'(o_eor));
                    lg_eof.push_back(int'(o_eof));
                    if (out_idx == m_total - 1) begin
                        nx_done = 1'b1;
                        m_busy  = 1'b0;
                        eof_cyc = cyc;
                    end
                    out_idx++;
                end
            end
            if (o_rdy && i_vld) begin
                acc_q.push_back(int'(i_data));
                acc_cnt++;
                nx_vld = 1'b1;
            end
            if (i_start && !busy_now) begin
                bad = (i_img_w == 0) || (i_img_h == 0) || (int'(i_img_w) > MAX_IMG_W)
                   || (int'(i_img_h) > MAX_IMG_H) || (int'(i_pad_rows) > KERNEL_H - 1);
                if (bad) begin
                    nx_err = 1'b1;
                end else begin
                    m_busy  = 1'b1;
                    m_w     = int'(i_img_w);
                    m_img   = int'(i_img_w) * int'(i_img_h);
                    m_total = int'(i_img_w) * (int'(i_img_h) + int'(i_pad_rows));
                    out_idx = 0;
                    acc_cnt = 0;
                    acc_q.delete();
                end
            end
            prev_hold = o_vld && !i_rdy;
            prev_d = int'(o_data); prev_eor = int'(o_eor); prev_eof = int'(o_eof);
            exp_done = nx_done; exp_err = nx_err; exp_vld = nx_vld;
        end
    end

    logic [DATA_W-1:0] src = 8'd1;

    task automatic step(input bit vld, input bit rdy);
        bit acc;
        @(negedge i_clk);
        acc = o_rdy && i_vld;
        @(posedge i_clk);
        #1;
        if (acc) src = src + 8'd1;
        i_data = src;
        i_vld  = vld;
        i_rdy  = rdy;
    endtask

    task automatic clear_logs();
        lg_d.delete(); lg_eor.delete(); lg_eof.delete();
        done_seen = 1'b0;
    endtask

    task automatic start_frame(input int w, input int h, input int pad);
        i_img_w    = W_W'(w);
        i_img_h    = H_W'(h);
        i_pad_rows = P_W'(pad);
        i_start    = 1'b1;
        step(i_vld, i_rdy);
        i_start    = 1'b0;
        i_img_w    = W_W'($urandom);
        i_img_h    = H_W'($urandom);
        i_pad_rows = P_W'($urandom);
    endtask

    task automatic run_frame(input int vld_pct, input int rdy_pct, input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            step($urandom_range(99) < vld_pct, $urandom_range(99) < rdy_pct);
            n++;
        end
        chk("frame_completes", int'(done_seen), 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    int t1_eor[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    int t1_eof[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    int t2_eor[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int t2_eof[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int base;

    initial begin
        i_data = src;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_vld", int'(o_vld), 0);
        chk("reset_data", int'(o_data), 0);
        chk("reset_eor_eof", int'({o_eor, o_eof}), 0);
        chk("reset_done_err", int'({o_done, o_err}), 0);
        i_rst_n = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Basic frame, pixels 1..8.
        clear_logs(); i_vld = 1'b1; i_rdy = 1'b1;
        start_frame(4, 2, 0);
        run_frame(100, 100, 60);
        chk("t1_beats", lg_d.size(), 8);
        for (int i = 0; i < 8 && i < lg_d.size(); i++) begin
            chk("t1_data", lg_d[i], i + 1);
            chk("t1_eor", lg_eor[i], t1_eor[i]);
            chk("t1_eof", lg_eof[i], t1_eof[i]);
        end
        chk("t1_done_latency", done_cyc - eof_cyc, 1);

        // Bottom padding.
        clear_logs(); i_vld = 1'b1;
        start_frame(3, 2, 2);
        run_frame(100, 100, 80);
        chk("t2_beats", lg_d.size(), 12);
        for (int i = 0; i < 12 && i < lg_d.size(); i++) begin
            chk("t2_eor", lg_eor[i], t2_eor[i]);
            chk("t2_eof", lg_eof[i], t2_eof[i]);
            if (i >= 6) chk("t2_pad_data", lg_d[i], 0);
        end

        // Backpressure mid-row.
        clear_logs(); i_vld = 1'b1; base = int'(src);
        start_frame(4, 1, 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        run_frame(100, 100, 60);
        chk("t3_beats", lg_d.size(), 4);
        for (int i = 0; i < 4 && i < lg_d.size(); i++) chk("t3_data", lg_d[i], (base + i) % 256);

        // Rejected geometry.
        clear_logs(); i_vld = 1'b0; err_seen = 0;
        start_frame(0, 2, 0);   step(1'b0, 1'b1);
        start_frame(641, 2, 0); step(1'b0, 1'b1);
        start_frame(4, 2, 7);   step(1'b0, 1'b1);
        chk("t4_err_pulses", err_seen, 3);
        chk("t4_busy", int'(o_busy), 0);

        // Reset mid-frame at row 1 col 2.
        clear_logs(); i_vld = 1'b1; i_rdy = 1'b1;
        start_frame(4, 3, 0);
        repeat (6) step(1'b1, 1'b1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("t5_async_vld", int'(o_vld), 0);
        chk("t5_async_data", int'(o_data), 0);
        chk("t5_async_flags", int'({o_eor, o_eof, o_busy, o_done, o_err, o_rdy}), 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        i_rst_n = 1'b1;
        step(1'b0, 1'b1);
        clear_logs(); i_vld = 1'b1;
        start_frame(2, 1, 0);
        run_frame(100, 100, 40);
        chk("t5_beats", lg_d.size(), 2);
        if (lg_d.size() == 2) begin
            chk("t5_eor0", lg_eor[0], 0); chk("t5_eof0", lg_eof[0], 0);
            chk("t5_eor1", lg_eor[1], 1); chk("t5_eof1", lg_eof[1], 1);
        end

        // Start during RUN is ignored.
        clear_logs(); i_vld = 1'b1;
        start_frame(5, 2, 1);
        repeat (3) step(1'b1, 1'b1);
        i_img_w = W_W'(2); i_img_h = H_W'(1); i_pad_rows = '0; i_start = 1'b1;
        step(1'b1, 1'b1);
        i_start = 1'b0;
        run_frame(100, 100, 80);
        chk("t6_beats", lg_d.size(), 15);

        // Start held through drain: only the idle cycle after done starts a new frame.
        clear_logs(); i_vld = 1'b1;
        start_frame(3, 1, 0);
        i_img_w = W_W'(2); i_img_h = H_W'(1); i_pad_rows = '0; i_start = 1'b1;
        while (!done_seen && cyc < 90000) step(1'b1, 1'b1);
        i_start = 1'b0;
        done_seen = 1'b0;
        run_frame(100, 100, 40);
        chk("t7_beats", lg_d.size(), 5);

        // Single-beat frame and size extremes.
        clear_logs(); start_frame(1, 1, 0); run_frame(100, 100, 20);
        chk("single_beats", lg_d.size(), 1);
        if (lg_d.size() == 1) chk("single_eor_eof", lg_eor[0] + lg_eof[0], 2);
        clear_logs(); start_frame(640, 1, 0); run_frame(90, 90, 3000);
        chk("wide_beats", lg_d.size(), 640);
        clear_logs(); start_frame(1, 480, 6); run_frame(90, 90, 3000);
        chk("tall_beats", lg_d.size(), 486);

        for (int f = 0; f < 40; f++) begin
            int w, h, p, vp, rp;
            w = $urandom_range(1, 8); h = $urandom_range(1, 4); p = $urandom_range(0, 6);
            vp = $urandom_range(50, 100); rp = $urandom_range(50, 100);
            clear_logs();
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(4))
                    0: w = 0;
                    1: h = 0;
                    2: w = $urandom_range(641, 1023);
                    3: h = $urandom_range(481, 511);
                    default: p = 7;
                endcase
                start_frame(w, h, p);
                step(1'b0, 1'b1);
                step(1'b0, 1'b1);
            end else begin
                i_vld = 1'b1;
                start_frame(w, h, p);
                run_frame(vp, rp, 8 * w * (h + p) + 50);
                chk("rand_beats", lg_d.size(), w * (h + p));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

endmodule
